// File: rtl/cla_serial_add16_ctrl_pkg.sv
// Shared types and constants for the nibble-serial 16-bit add/sub controller.
package cla_serial_add16_ctrl_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cla_serial_add16_ctrl_if.sv
// Request/result bundle between a requester and the serial add/sub controller.
interface cla_serial_add16_ctrl_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         Start;
  logic         Sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Sum;
  logic         CO;
  logic         V;
  logic         Busy;
  logic         Done;

  modport master (output Start, Sub, A, B, input Sum, CO, V, Busy, Done);
  modport slave  (input Start, Sub, A, B, output Sum, CO, V, Busy, Done);
endinterface

// File: rtl/cla_serial_add16_ctrl_cla4.sv
// 4-bit carry-lookahead adder slice; carries come from generate/propagate terms.
module carry_lookahead_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [3:1] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ {c[3], c[2], c[1], ci};
endmodule

// File: rtl/cla_serial_add16_ctrl.sv
// W-bit add/subtract done by reusing one 4-bit CLA slice, LS nibble first.
// Subtract is A + ~B + 1: the inverted B is captured and the carry seeded with 1.
module cla_serial_add16_ctrl
  import cla_serial_add16_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  cla_serial_add16_ctrl_if.slave     bus
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t state, state_nxt;

  logic [NIBBLES-1:0][SLICE_W-1:0] opa, opb, sum_q;
  logic                            cy, co_q, v_q;
  logic [IDX_W-1:0]                idx;
  logic [SLICE_W-1:0]              s_sl;
  logic                            co_sl;
  logic                            last;

  assign last = (idx == IDX_W'(NIBBLES - 1));

  carry_lookahead_adder4 u_cla (
    .a  (opa[idx]),
    .b  (opb[idx]),
    .ci (cy),
    .s  (s_sl),
    .co (co_sl)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // DONE waits for Start to drop so a held request never retriggers.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (!bus.Start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      opa   <= '0;
      opb   <= '0;
      sum_q <= '0;
      cy    <= 1'b0;
      co_q  <= 1'b0;
      v_q   <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.Start) begin
          opa   <= bus.A;
          opb   <= bus.Sub ? ~bus.B : bus.B;
          cy    <= bus.Sub;
          idx   <= '0;
          sum_q <= '0;
          co_q  <= 1'b0;
          v_q   <= 1'b0;
        end
        RUN: begin
          sum_q[idx] <= s_sl;
          cy         <= co_sl;
          if (last) begin
            co_q <= co_sl;
            // Overflow: like-signed operands produced a result of the other sign.
            v_q  <= (opa[NIBBLES-1][SLICE_W-1] == opb[NIBBLES-1][SLICE_W-1]) &&
                    (s_sl[SLICE_W-1] != opa[NIBBLES-1][SLICE_W-1]);
            idx  <= '0;
          end else begin
            idx  <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Sum  = sum_q;
  assign bus.CO   = co_q;
  assign bus.V    = v_q;
  assign bus.Busy = (state == RUN);
  assign bus.Done = (state == DONE);
endmodule

// File: doc/cla_serial_add16_ctrl.md
# cla_serial_add16_ctrl

Sequencing controller that performs a 16-bit add or subtract by time-multiplexing a single 4-bit carry-lookahead adder slice over four cycles, least-significant nibble first. It captures operands on a start handshake, iterates the slice with a registered inter-nibble carry, accumulates the result nibble by nibble, and raises Done with result and flags. It serves as the area-saving alternative to a full-width adder in the lab adder datapath.

## Interface
- NIBBLES, 4, number of 4-bit slice passes; operand width W = 4*NIBBLES
- Clk  input  1  system clock, rising-edge
- Reset  input  1  asynchronous, active-high; one clock domain (Clk), reset asserts immediately, deasserts synchronously to Clk by system convention
- Start  input  1  request; sampled only in IDLE
- Sub  input  1  0 = A+B, 1 = A-B; captured with operands
- A  input  W  operand A; captured on start
- B  input  W  operand B; captured on start
- Sum  output  W  result register
- CO  output  1  carry out of MSB nibble (subtract: 1 = no borrow, A >= B unsigned)
- V  output  1  signed two's-complement overflow
- Busy  output  1  high in RUN
- Done  output  1  high in DONE; result valid

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE; Sum=0, CO=0, V=0, Busy=0, Done=0, nibble index=0, carry reg=0.
- IDLE: Start=1 at a Clk edge -> capture A into opA, (Sub ? ~B : B) into opB, carry reg <= Sub, index <= 0, Sum <= 0, CO <= 0, V <= 0; go RUN. Start=0 -> stay.
- RUN: slice inputs are opA[4i+3:4i], opB[4i+3:4i], carry reg, where i = index. Each edge: Sum[4i+3:4i] <= slice sum, carry reg <= slice carry out, index <= i+1.
- At i = NIBBLES-1: additionally CO <= slice carry out, V <= (opA[W-1] == opB[W-1]) && (slice sum[3] != opA[W-1]); go DONE; index wraps to 0.
- DONE: Done=1; Sum/CO/V held. Leaves to IDLE only when Start=0 (no retrigger while Start held high). Start=1 in DONE -> stay.
- A, B, and Sub changes after capture are ignored until the next IDLE capture.
- Sum nibbles update progressively during RUN; Sum is valid only when Done=1.
- Arithmetic is modulo 2^W; no saturation.
- Reset mid-RUN or mid-DONE: immediate abort, all outputs and state return to reset values, and no partial result is retained.

## Timing
- Capture edge E0 (IDLE, Start=1). Nibble i is written on edge E(i+1). DONE is entered on edge E(NIBBLES); Done is first high in the cycle after E4 for default NIBBLES = 4.
- Throughput: one operation per NIBBLES+2 cycles minimum (capture, NIBBLES passes, one DONE cycle with Start low).
- Busy and Done are registered state decodes with no combinational path from Start, and are never high together.
- Slice path: register -> 4-bit CLA -> register within one cycle; no multicycle paths.

## Structure
- Shared package: state enum (IDLE, RUN, DONE) and constant SLICE_W = 4.
- One sub-module: carry_lookahead_adder4, the existing 4-bit CLA slice, instantiated exactly once; all sequencing, muxing, and flag logic live in this block.
- Index counter width is $clog2(NIBBLES), minimum 1.

## Test plan
- Add 0x1234 + 0x4321, Sub=0 -> Sum=0x5555, CO=0, V=0; Done first high 4 edges after capture edge; Busy high exactly 4 cycles.
- Add 0xFFFF + 0x0001 -> Sum=0x0000, CO=1, V=0, which checks carry ripple through all four passes. Add 0x7FFF + 0x0001 -> Sum=0x8000, CO=0, V=1.
- Sub 0x0005 - 0x0007 -> Sum=0xFFFE, CO=0, V=0. Sub 0x8000 - 0x0001 -> Sum=0x7FFF, CO=1, V=1.
- Start held high through DONE for 10 cycles -> single operation, Done stays high, no re-capture. Drop Start -> IDLE next edge. Reassert Start with new operands -> new result.
- Change A and B on every cycle during RUN -> result reflects captured operands only.
- Assert Reset asynchronously mid-RUN (between edges after nibble 1 written) -> Sum, CO, V, Busy, and Done are 0 immediately. After release, a fresh 0x00FF + 0x0001 yields 0x0100.
